// File: rtl/vga_timing_gen_pkg.sv
// vga_pkg: shared raster timing constants, helpers and sync bundle
// for the VGA timing generator and its delay line.
package vga_pkg;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;

  function automatic int span_total(
    input int vis, input int fp,
    input int sync, input int bp
  );
    return vis + fp + sync + bp;
  endfunction

  function automatic int sync_start(
    input int vis, input int fp
  );
    return vis + fp;
  endfunction

  function automatic int sync_end(
    input int vis, input int fp, input int sync
  );
    return vis + fp + sync;
  endfunction

  localparam int H_TOTAL = span_total(
    H_VISIBLE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL = span_total(
    V_VISIBLE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);
  localparam int H_SYNC_START = sync_start(H_VISIBLE_DEF, H_FP_DEF);
  localparam int H_SYNC_END   = sync_end(
    H_VISIBLE_DEF, H_FP_DEF, H_SYNC_DEF);
  localparam int V_SYNC_START = sync_start(V_VISIBLE_DEF, V_FP_DEF);
  localparam int V_SYNC_END   = sync_end(
    V_VISIBLE_DEF, V_FP_DEF, V_SYNC_DEF);

  typedef struct packed {
    logic blank;
    logic hs;
    logic vs;
  } vga_sync_t;

  // Blanking with both syncs released.
  localparam vga_sync_t SYNC_IDLE = '{blank: 1'b0, hs: 1'b1, vs: 1'b1};

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle: coordinates, sync/blank, frame events.
// master drives it, slave (colour mapper / DAC side) consumes it.
interface vga_timing_gen_if;
  logic       pix_en;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       Blank;
  logic       hs;
  logic       vs;
  logic       frame_start;
  logic [7:0] frame_count;
  logic       blink;

  modport master (
    output pix_en, DrawX, DrawY, Blank, hs, vs,
    output frame_start, frame_count, blink
  );

  modport slave (
    input pix_en, DrawX, DrawY, Blank, hs, vs,
    input frame_start, frame_count, blink
  );
endinterface

// File: rtl/vga_timing_gen_sync_delay_line.sv
// sync_delay_line: enable-gated shift register for the sync bundle,
// lining Blank/hs/vs up with downstream ROM read latency.
module sync_delay_line
  import vga_pkg::*;
#(
  parameter int        DEPTH   = 1,
  parameter vga_sync_t RST_VAL = SYNC_IDLE
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      en,
  input  vga_sync_t d,
  output vga_sync_t q
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst, en};
    assign q = d;
  end else begin : g_shift
    vga_sync_t stg_q [DEPTH];
    vga_sync_t stg_d [DEPTH];

    // Shift one slot per pixel strobe, hold otherwise.
    always_comb begin
      for (int i = 0; i < DEPTH; i++) stg_d[i] = stg_q[i];
      if (en) begin
        stg_d[0] = d;
        for (int i = 1; i < DEPTH; i++) stg_d[i] = stg_q[i-1];
      end
    end

    // Stage registers; reset parks every stage at the idle value.
    always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rst) stg_q[i] <= RST_VAL;
        else     stg_q[i] <= stg_d[i];
      end
    end

    assign q = stg_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-strobe divider, raster counters, sync decode
// with latency-matching delay line, frame pulse and blink flag.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE    = H_VISIBLE_DEF,
  parameter int H_FP         = H_FP_DEF,
  parameter int H_SYNC       = H_SYNC_DEF,
  parameter int H_BP         = H_BP_DEF,
  parameter int V_VISIBLE    = V_VISIBLE_DEF,
  parameter int V_FP         = V_FP_DEF,
  parameter int V_SYNC       = V_SYNC_DEF,
  parameter int V_BP         = V_BP_DEF,
  parameter int CLK_DIV      = 2,
  parameter int PIPE_DELAY   = 1,
  parameter int BLINK_FRAMES = 16
) (
  input logic              CLK,
  input logic              Reset,
  vga_timing_gen_if.master vga
);

  localparam int HT = span_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int VT = span_total(V_VISIBLE, V_FP, V_SYNC, V_BP);
  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int BLK_W = $clog2(BLINK_FRAMES) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [9:0] H_LAST = 10'(HT - 1);
  localparam logic [9:0] V_LAST = 10'(VT - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] H_SS   = 10'(sync_start(H_VISIBLE, H_FP));
  localparam logic [9:0] H_SE   = 10'(sync_end(H_VISIBLE, H_FP, H_SYNC));
  localparam logic [9:0] V_SS   = 10'(sync_start(V_VISIBLE, V_FP));
  localparam logic [9:0] V_SE   = 10'(sync_end(V_VISIBLE, V_FP, V_SYNC));

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             pix_en_q, pix_en_d;
  logic [9:0]       draw_x_q, draw_x_d;
  logic [9:0]       draw_y_q, draw_y_d;
  logic             frame_start_q, frame_start_d;
  logic [7:0]       frame_count_q, frame_count_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_q, blink_d;

  logic      div_last;
  logic      x_last;
  logic      y_last;
  logic      frame_evt;
  vga_sync_t sync_raw;
  vga_sync_t sync_dly;

  // Pixel-slot divider and raster counters, stepping on the strobe.
  always_comb begin
    div_last  = (div_cnt_q == DIV_LAST);
    div_cnt_d = div_last ? '0 : div_cnt_q + DIV_W'(1);
    pix_en_d  = div_last;
    x_last    = (draw_x_q == H_LAST);
    y_last    = (draw_y_q == V_LAST);
    frame_evt = pix_en_q && x_last && y_last;
    draw_x_d  = draw_x_q;
    draw_y_d  = draw_y_q;
    if (pix_en_q) begin
      if (x_last) begin
        draw_x_d = '0;
        draw_y_d = y_last ? '0 : draw_y_q + 10'd1;
      end else begin
        draw_x_d = draw_x_q + 10'd1;
      end
    end
  end

  // Frame pulse, frame counter and blink half-period tracking.
  always_comb begin
    frame_start_d = frame_evt;
    frame_count_d = frame_count_q;
    blink_cnt_d   = blink_cnt_q;
    blink_d       = blink_q;
    if (frame_evt) begin
      frame_count_d = frame_count_q + 8'd1;
      if (blink_cnt_q == BLK_LAST) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end
  end

  // Undelayed visible/sync decode of the current counters.
  always_comb begin
    sync_raw       = SYNC_IDLE;
    sync_raw.blank = (draw_x_q < H_VIS) && (draw_y_q < V_VIS);
    sync_raw.hs    = !((draw_x_q >= H_SS) && (draw_x_q < H_SE));
    sync_raw.vs    = !((draw_y_q >= V_SS) && (draw_y_q < V_SE));
  end

  // State registers; Reset overrides everything.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      div_cnt_q     <= '0;
      pix_en_q      <= 1'b0;
      draw_x_q      <= '0;
      draw_y_q      <= '0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
      blink_cnt_q   <= '0;
      blink_q       <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      pix_en_q      <= pix_en_d;
      draw_x_q      <= draw_x_d;
      draw_y_q      <= draw_y_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_q       <= blink_d;
    end
  end

  sync_delay_line #(
    .DEPTH   (PIPE_DELAY),
    .RST_VAL (SYNC_IDLE)
  ) u_dly (
    .clk (CLK),
    .rst (Reset),
    .en  (pix_en_q),
    .d   (sync_raw),
    .q   (sync_dly)
  );

  assign vga.pix_en      = pix_en_q;
  assign vga.DrawX       = draw_x_q;
  assign vga.DrawY       = draw_y_q;
  assign vga.Blank       = sync_dly.blank;
  assign vga.hs          = sync_dly.hs;
  assign vga.vs          = sync_dly.vs;
  assign vga.frame_start = frame_start_q;
  assign vga.frame_count = frame_count_q;
  assign vga.blink       = blink_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: per-pixel expectations queued per instance,
// monitors pop and compare on every pixel strobe.
module tb_vga_timing_gen;
  import vga_pkg::*;

  typedef struct {
    int n;
    int x;
    int y;
    bit blank;
    bit hs;
    bit vs;
    int fc;
    bit blink;
  } exp_t;

  logic   CLK = 1'b0;
  logic   Reset = 1'b1;
  logic   rst_q = 1'b1;
  longint cyc = 0;
  int     checks = 0;
  int     errors = 0;
  exp_t   sb [4][$];
  int     pd_t [4] = '{1, 1, 0, 3};
  int     bf_t [4] = '{16, 2, 2, 1};
  int     dv_t [4] = '{2, 2, 1, 1};

  always #5 CLK = ~CLK;

  // Reset as seen by the DUT at the last rising edge.
  always @(posedge CLK) begin
    cyc   <= cyc + 1;
    rst_q <= Reset;
  end

  vga_timing_gen_if ifa ();
  vga_timing_gen_if ifb ();
  vga_timing_gen_if ifc ();
  vga_timing_gen_if ifd ();

  vga_timing_gen u_a (.CLK(CLK), .Reset(Reset), .vga(ifa));

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(2), .PIPE_DELAY(1), .BLINK_FRAMES(2)
  ) u_b (.CLK(CLK), .Reset(Reset), .vga(ifb));

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(1), .PIPE_DELAY(0), .BLINK_FRAMES(2)
  ) u_c (.CLK(CLK), .Reset(Reset), .vga(ifc));

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(1), .PIPE_DELAY(3), .BLINK_FRAMES(1)
  ) u_d (.CLK(CLK), .Reset(Reset), .vga(ifd));

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int id, input int n);
    exp_t e;
    int hv = 8, hf = 2, hw = 3, hb = 3;
    int vv = 6, vf = 1, vw = 2, vb = 1;
    int ht, vt, m, mx, my, fr;
    if (id == 0) begin
      hv = 640; hf = 16; hw = 96; hb = 48;
      vv = 480; vf = 10; vw = 2;  vb = 33;
    end
    ht = hv + hf + hw + hb;
    vt = vv + vf + vw + vb;
    fr = n / (ht * vt);
    e.n     = n;
    e.x     = n % ht;
    e.y     = (n / ht) % vt;
    e.fc    = fr % 256;
    e.blink = ((fr / bf_t[id]) % 2) == 1;
    m = n - pd_t[id];
    if (m < 0) begin
      e.blank = 1'b0;
      e.hs    = 1'b1;
      e.vs    = 1'b1;
    end else begin
      mx = m % ht;
      my = (m / ht) % vt;
      e.blank = (mx < hv) && (my < vv);
      e.hs = !(mx >= hv + hf && mx < hv + hf + hw);
      e.vs = !(my >= vv + vf && my < vv + vf + vw);
    end
    return e;
  endfunction

  task automatic push(input int id, input int cnt);
    sb[id].delete();
    for (int n = 0; n < cnt; n++) sb[id].push_back(model(id, n));
  endtask

  task automatic monitor(input int id,
                         input virtual vga_timing_gen_if vif);
    longint last = -1;
    exp_t   e;
    string  p;
    forever begin
      @(negedge CLK);
      if (rst_q) begin
        last = -1;
      end else if (vif.pix_en) begin
        if (last >= 0)
          chk($sformatf("%0d.pix_en_gap", id), cyc - last, dv_t[id]);
        last = cyc;
        if (sb[id].size() > 0) begin
          e = sb[id].pop_front();
          p = $sformatf("%0d.n%0d", id, e.n);
          chk({p, ".DrawX"}, vif.DrawX, e.x);
          chk({p, ".DrawY"}, vif.DrawY, e.y);
          chk({p, ".Blank"}, vif.Blank, e.blank);
          chk({p, ".hs"}, vif.hs, e.hs);
          chk({p, ".vs"}, vif.vs, e.vs);
          chk({p, ".frame_count"}, vif.frame_count, e.fc);
          chk({p, ".blink"}, vif.blink, e.blink);
        end
      end
    end
  endtask

  task automatic chk_reset(input string nm,
                           input virtual vga_timing_gen_if vif);
    chk({nm, ".rst.pix_en"}, vif.pix_en, 0);
    chk({nm, ".rst.DrawX"}, vif.DrawX, 0);
    chk({nm, ".rst.DrawY"}, vif.DrawY, 0);
    chk({nm, ".rst.Blank"}, vif.Blank, 0);
    chk({nm, ".rst.hs"}, vif.hs, 1);
    chk({nm, ".rst.vs"}, vif.vs, 1);
    chk({nm, ".rst.frame_start"}, vif.frame_start, 0);
    chk({nm, ".rst.frame_count"}, vif.frame_count, 0);
    chk({nm, ".rst.blink"}, vif.blink, 0);
  endtask

  initial monitor(0, ifa);
  initial monitor(1, ifb);
  initial monitor(2, ifc);
  initial monitor(3, ifd);

  // Frame pulse spacing on the small CLK_DIV=2 raster: 16*10*2.
  initial begin
    longint last_fs = -1;
    forever begin
      @(negedge CLK);
      if (rst_q) begin
        last_fs = -1;
      end else if (ifb.frame_start) begin
        if (last_fs >= 0) chk("b.frame_period", cyc - last_fs, 320);
        last_fs = cyc;
      end
    end
  end

  initial begin
    int found;
    push(0, 820);
    push(1, 481);
    push(2, 961);
    push(3, 321);
    repeat (5) @(negedge CLK);
    chk_reset("a", ifa);
    chk_reset("b", ifb);
    Reset = 1'b0;
    @(negedge CLK);
    chk("a.first_pix_en_c1", ifa.pix_en, 0);
    @(negedge CLK);
    chk("a.first_pix_en_c2", ifa.pix_en, 1);
    repeat (2000) @(negedge CLK);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%0d.drain1", i), sb[i].size(), 0);
    chk("b.frame_count_pre", ifb.frame_count, 6);

    found = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge CLK);
      if (ifb.DrawX == 10'd5 && ifb.DrawY == 10'd3) begin
        found = 1;
        break;
      end
    end
    chk("b.reach_mid_frame", found, 1);
    Reset = 1'b1;
    @(negedge CLK);
    chk_reset("a", ifa);
    chk_reset("b", ifb);
    push(0, 20);
    push(1, 161);
    push(2, 170);
    push(3, 170);
    Reset = 1'b0;

    found = 0;
    for (int j = 1; j <= 400; j++) begin
      @(negedge CLK);
      if (ifb.frame_start) begin
        found = j;
        break;
      end
    end
    chk("b.first_frame_start_after_reset", found, 321);
    repeat (100) @(negedge CLK);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%0d.drain2", i), sb[i].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
